// File: rtl/uart_tx_arbiter.sv
// Frame-level round-robin arbiter sharing one uart_tx byte port among NUM_REQ requesters.
// Optional feature macro UART_ARB_SRC_TAG_EN prefixes every frame with a source tag byte.
`timescale 1ns/1ps
module uart_tx_arbiter #(
   parameter int         NUM_REQ     = 4,
   parameter int         ID_W        = 2,
   parameter int         TIMEOUT_CYC = 5000,
   parameter logic [7:0] TAG_BASE    = 8'hF0
) (
   input  logic                 clk_50m,
   input  logic                 reset_n,
   input  logic [NUM_REQ-1:0]   req_valid,
   input  logic [NUM_REQ*8-1:0] req_data,
   input  logic [NUM_REQ-1:0]   req_last,
   output logic [NUM_REQ-1:0]   req_ready,
   output logic [7:0]           tx_data,
   output logic                 tx_start,
   input  logic                 tx_busy,
   output logic [ID_W-1:0]      grant_id,
   output logic                 grant_active,
   output logic                 timeout_err
);
   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_XFER  = 3'd1,
      S_GUARD = 3'd2,
      S_WAIT  = 3'd3
`ifdef UART_ARB_SRC_TAG_EN
      , S_TAG = 3'd4
`endif
   } state_t;

   state_t          state_q, state_d;
   logic [ID_W-1:0] rr_ptr_q, rr_ptr_d;
   logic [ID_W-1:0] grant_id_q, grant_id_d;
   logic [31:0]     cnt_q, cnt_d;
   logic            grant_active_q, grant_active_d;
   logic [7:0]      tx_data_q, tx_data_d;
   logic            tx_start_q, tx_start_d;
   logic            timeout_err_q, timeout_err_d;
   logic            last_q, last_d;

   logic [ID_W-1:0] winner_s;
   logic            found_s;
   logic            any_req_s;
   logic            hs_s;
   logic            stall_s;
   logic            wd_fire_s;
   logic [ID_W-1:0] next_ptr_s;

   assign any_req_s  = |req_valid;
   assign hs_s       = (state_q == S_XFER) && !tx_busy && req_valid[grant_id_q];
   assign stall_s    = (state_q == S_XFER) && !tx_busy && !req_valid[grant_id_q];
   assign wd_fire_s  = (TIMEOUT_CYC != 0) && stall_s && (cnt_q == 32'(TIMEOUT_CYC - 1));
   assign next_ptr_s = ID_W'((int'(grant_id_q) + 1) % NUM_REQ);

   // first requester at or above rr_ptr (wrapping) that has a byte waiting
   always_comb begin
      winner_s = '0;
      found_s  = 1'b0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (!found_s && req_valid[(int'(rr_ptr_q) + i) % NUM_REQ]) begin
            winner_s = ID_W'((int'(rr_ptr_q) + i) % NUM_REQ);
            found_s  = 1'b1;
         end else begin
            found_s  = found_s;
         end
      end
   end

   // only the owner may hand over a byte, and only while uart_tx is free
   always_comb begin
      req_ready = '0;
      if (state_q == S_XFER && !tx_busy) begin
         req_ready[grant_id_q] = 1'b1;
      end else begin
         req_ready = '0;
      end
   end

   // next-state and registered-output logic
   always_comb begin
      state_d        = state_q;
      rr_ptr_d       = rr_ptr_q;
      grant_id_d     = grant_id_q;
      cnt_d          = cnt_q;
      grant_active_d = grant_active_q;
      tx_data_d      = tx_data_q;
      tx_start_d     = 1'b0;
      timeout_err_d  = 1'b0;
      last_d         = last_q;
      case (state_q)
         S_IDLE: begin
            cnt_d = 32'd0;
            if (any_req_s) begin
               grant_id_d     = winner_s;
               grant_active_d = 1'b1;
`ifdef UART_ARB_SRC_TAG_EN
               state_d        = S_TAG;
`else
               state_d        = S_XFER;
`endif
            end else begin
               grant_active_d = 1'b0;
            end
         end
`ifdef UART_ARB_SRC_TAG_EN
         S_TAG: begin
            if (!tx_busy) begin
               tx_data_d  = {TAG_BASE[7:4], 4'(grant_id_q)};
               tx_start_d = 1'b1;
               last_d     = 1'b0;
               state_d    = S_GUARD;
            end else begin
               state_d    = S_TAG;
            end
         end
`endif
         S_XFER: begin
            if (hs_s) begin
               tx_data_d  = req_data[{grant_id_q, 3'b000} +: 8];
               tx_start_d = 1'b1;
               last_d     = req_last[grant_id_q];
               cnt_d      = 32'd0;
               state_d    = S_GUARD;
            end else if (wd_fire_s) begin
               state_d        = S_IDLE;
               grant_active_d = 1'b0;
               rr_ptr_d       = next_ptr_s;
               timeout_err_d  = 1'b1;
               cnt_d          = 32'd0;
            end else if (stall_s && TIMEOUT_CYC != 0) begin
               cnt_d = cnt_q + 32'd1;
            end else begin
               // a busy transmitter breaks the run of consecutive stall cycles
               cnt_d = 32'd0;
            end
         end
         S_GUARD: begin
            state_d = S_WAIT;
         end
         S_WAIT: begin
            if (!tx_busy) begin
               if (last_q) begin
                  state_d        = S_IDLE;
                  grant_active_d = 1'b0;
                  rr_ptr_d       = next_ptr_s;
               end else begin
                  state_d = S_XFER;
                  cnt_d   = 32'd0;
               end
            end else begin
               state_d = S_WAIT;
            end
         end
         default: begin
            state_d        = S_IDLE;
            grant_active_d = 1'b0;
         end
      endcase
   end

   // state and output registers
   always_ff @(posedge clk_50m) begin
      if (!reset_n) begin
         state_q        <= S_IDLE;
         rr_ptr_q       <= '0;
         grant_id_q     <= '0;
         cnt_q          <= 32'd0;
         grant_active_q <= 1'b0;
         tx_data_q      <= 8'h00;
         tx_start_q     <= 1'b0;
         timeout_err_q  <= 1'b0;
         last_q         <= 1'b0;
      end else begin
         state_q        <= state_d;
         rr_ptr_q       <= rr_ptr_d;
         grant_id_q     <= grant_id_d;
         cnt_q          <= cnt_d;
         grant_active_q <= grant_active_d;
         tx_data_q      <= tx_data_d;
         tx_start_q     <= tx_start_d;
         timeout_err_q  <= timeout_err_d;
         last_q         <= last_d;
      end
   end

   assign tx_data      = tx_data_q;
   assign tx_start     = tx_start_q;
   assign grant_id     = grant_id_q;
   assign grant_active = grant_active_q;
   assign timeout_err  = timeout_err_q;
endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
Shares the board's single UART transmitter between NUM_REQ byte-stream requesters, e.g. the LED status reporter, the loopback echo and the debug dump.
- Frame-level round-robin: once a requester is granted, it keeps the transmitter until its byte flagged last has been sent.
- Sits between the requesters and the uart_tx byte interface (tx_data/tx_start/tx_busy), which drives uart_tx_path.
- A stall watchdog releases a requester that stops mid-frame.

Parameters:
NUM_REQ, 4, number of requesters (1..16)
ID_W, 2, grant_id width = max(1, clog2(NUM_REQ))
TIMEOUT_CYC, 5000, stall limit in clk_50m cycles (100 us); 0 disables the watchdog
TAG_BASE, 8'hF0, upper nibble of the source tag byte (used only with the optional feature)

Ports:
clk_50m  in  1  system clock, 50 MHz
reset_n  in  1  reset, synchronous, active-low
req_valid  in  NUM_REQ  per-requester byte valid
req_data  in  NUM_REQ*8  per-requester byte; requester i occupies bits [8i+7:8i]
req_last  in  NUM_REQ  byte is the last of its frame
req_ready  out  NUM_REQ  byte accepted when valid&ready
tx_data  out  8  byte to uart_tx
tx_start  out  1  one-cycle start pulse to uart_tx
tx_busy  in  1  uart_tx busy; rises the cycle after tx_start, falls after the stop bit
grant_id  out  ID_W  index of the current owner
grant_active  out  1  a frame is in progress
timeout_err  out  1  one-cycle pulse when the watchdog releases an owner

Behaviour:
- Reset (reset_n low at a clk_50m edge): state IDLE, rr_ptr=0, stall count=0.
- All outputs reset to 0: tx_data=8'h00, tx_start, grant_id, grant_active, timeout_err, req_ready.
- Reset mid-frame aborts the frame. A byte already started on uart_tx is not recalled.
- All outputs are registered except req_ready.
- req_ready[i] = (state==XFER) & (i==grant_id) & !tx_busy; all other bits are 0.
- IDLE:
  - If any req_valid is high, grant the first requester found searching upward from rr_ptr with wrap-around.
  - Next cycle: grant_id=winner, grant_active=1, state XFER.
  - Requesters are sampled only in IDLE. Simultaneous requests are resolved purely by rr_ptr.
- XFER, on handshake:
  - Next cycle: tx_data=req_data[g], tx_start=1 for exactly one cycle, last_q=req_last[g], state GUARD.
  - Latency from accepting handshake to tx_start is 1 cycle.
- GUARD: one cycle, allowing uart_tx to assert tx_busy, then state WAIT.
- WAIT, when tx_busy is low:
  - If last_q: state IDLE, grant_active=0, rr_ptr=(g+1) mod NUM_REQ.
  - Otherwise: state XFER.
- Frame lock: other requesters' req_ready stays 0 for the whole frame, whatever their req_valid.
- Watchdog (TIMEOUT_CYC>0):
  - Counts XFER cycles with req_valid[g]=0 and tx_busy=0.
  - The count clears on entry to XFER and on any handshake.
  - When TIMEOUT_CYC consecutive such cycles have elapsed: state IDLE, grant_active=0, rr_ptr=(g+1) mod NUM_REQ, timeout_err=1 for one cycle.
- NUM_REQ=1: rr_ptr is always 0 and the arbiter degenerates to pass-through with framing.
- req_data and req_last of a requester that is not granted are ignored.

Optional Feature:
UART_ARB_SRC_TAG_EN
- Defined:
  - IDLE→XFER goes via TAG.
  - In TAG, when tx_busy is low: tx_data={TAG_BASE[7:4], 4-bit grant_id}, tx_start pulse, then GUARD→WAIT→XFER, with last_q forced to 0.
  - Every frame on the line is prefixed by one source tag byte.
  - The watchdog does not run in TAG.
- Undefined: no TAG state; frames are sent untagged.

Test Plan:
- Bench uart_tx model: tx_busy high 10 cycles after each tx_start.
- Reset: hold reset_n low 3 cycles with req_valid=4'hF -> all outputs 0; after release, first grant_id=0.
- Single frame: req1 sends 8'h11, 8'h22, 8'h33 (last on 8'h33) -> three tx_start pulses carrying 11,22,33; grant_id=1 throughout; grant_active drops after the third busy falls.
- Round-robin: all four requesters each post a 1-byte frame (8'hA0..8'hA3) simultaneously -> tx order A0,A1,A2,A3. Then req0 and req2 post -> order req0 then req2.
- Frame lock: req0 posts a 2-byte frame (8'h10, 8'h11 last) while req1 holds valid with 8'h20 -> tx sequence 10,11,20; req_ready[1] stays 0 until req0's frame ends.
- Watchdog: TIMEOUT_CYC=16, req2 sends 8'h55 (not last) then drops valid, req3 pending -> timeout_err pulses 16 cycles after XFER re-entry; next grant_id=3.
- Tag (UART_ARB_SRC_TAG_EN defined, TAG_BASE=8'hF0): req2 sends 1 byte 8'h7E -> tx sequence F2,7E. Reset mid-frame -> outputs 0 and the next frame starts with its tag.
